// File: rtl/ones_pattern_gen.sv
`timescale 1ns/1ps
// Serial ones-pattern generator: builds q = (1<<min(cnt,W))-1 one bit per clock via a right shift.
// Optional LSB-first serial output enabled by defining ONES_PATTERN_SERIAL_EN.
module ones_pattern_gen #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          sat
`ifdef ONES_PATTERN_SERIAL_EN
  ,
  output logic          sout
`endif
);

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_BUILD = 1'b1;
  localparam logic [CW-1:0] W_C     = CW'(W);
  localparam logic [CW-1:0] LAST_C  = CW'(W - 1);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_lat_q, cnt_lat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sat_q, sat_d;
  logic          shift_bit;
`ifdef ONES_PATTERN_SERIAL_EN
  logic          sout_q, sout_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      idx_q     <= '0;
      cnt_lat_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
`ifdef ONES_PATTERN_SERIAL_EN
      sout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      idx_q     <= idx_d;
      cnt_lat_q <= cnt_lat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
`ifdef ONES_PATTERN_SERIAL_EN
      sout_q    <= sout_d;
`endif
    end
  end

  // Next-state and output logic; done and sout are single-cycle unless re-asserted
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    idx_d     = idx_q;
    cnt_lat_d = cnt_lat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sat_d     = sat_q;
    shift_bit = 1'b0;
`ifdef ONES_PATTERN_SERIAL_EN
    sout_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (load) begin
          cnt_lat_d = (cnt > W_C) ? W_C : cnt;
          sat_d     = (cnt > W_C);
          q_d       = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_BUILD;
        end
      end
      S_BUILD: begin
        // First bit shifted in ends up at the LSB after W shifts
        shift_bit = (idx_q < cnt_lat_q);
        q_d       = {shift_bit, q_q[W-1:1]};
        idx_d     = idx_q + CW'(1);
`ifdef ONES_PATTERN_SERIAL_EN
        sout_d    = shift_bit;
`endif
        if (idx_q == LAST_C) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sat  = sat_q;
`ifdef ONES_PATTERN_SERIAL_EN
  assign sout = sout_q;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
`timescale 1ns/1ps
// Directed plus randomized bench for ones_pattern_gen against an arithmetic reference model.
module tb_ones_pattern_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic [W-1:0]  q;
  logic          busy, done, sat;
`ifdef ONES_PATTERN_SERIAL_EN
  logic          sout;
`endif

  int total = 0;
  int bad = 0;
  int sout_ones = 0;

  ones_pattern_gen #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .cnt   (cnt),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .sat   (sat)
`ifdef ONES_PATTERN_SERIAL_EN
    ,
    .sout  (sout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(input int c);
    return (c > int'(W)) ? int'(W) : c;
  endfunction

  function automatic logic [31:0] model_q(input int c);
    longint one = 1;
    return 32'((one << clamp(c)) - 1);
  endfunction

  // Accept edge: busy rises, q clears, done drops, sat reflects the request
  task automatic start(input int c);
    load = 1'b1;
    cnt  = CW'(c);
    tick();
    load = 1'b0;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_done", 32'(done), 32'd0);
    chk("acc_q", 32'(q), 32'd0);
    chk("acc_sat", 32'(sat), 32'(c > int'(W)));
    sout_ones = 0;
  endtask

  // W build edges; optional ignored load request at build cycle ign_at
  task automatic finish(input int c, input int ign_at);
    for (int i = 1; i <= int'(W); i++) begin
      if (i == ign_at) begin
        load = 1'b1;
        cnt  = CW'(1);
      end
      tick();
      load = 1'b0;
`ifdef ONES_PATTERN_SERIAL_EN
      if (sout === 1'b1) sout_ones++;
`endif
      if (i < int'(W)) begin
        chk("bld_busy", 32'(busy), 32'd1);
        chk("bld_done", 32'(done), 32'd0);
      end
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("q", 32'(q), model_q(c));
    chk("sat", 32'(sat), 32'(c > int'(W)));
    chk("popcount", 32'($countones(q)), 32'(clamp(c)));
`ifdef ONES_PATTERN_SERIAL_EN
    chk("sout_ones", 32'(sout_ones), 32'(clamp(c)));
`endif
  endtask

  task automatic hold_check(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_done", 32'(done), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_q", 32'(q), model_q(c));
      chk("hold_sat", 32'(sat), 32'(c > int'(W)));
    end
  endtask

  initial begin
    int c;
    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_q", 32'(q), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_sat", 32'(sat), 32'd0);

    // Basic build and hold
    start(3);
    finish(3, -1);
    hold_check(3, 3);

    // Boundaries and saturation, then sat clears on next load
    start(0);  finish(0, -1);  hold_check(0, 1);
    start(8);  finish(8, -1);  hold_check(8, 1);
    start(15); finish(15, -1); hold_check(15, 2);
    start(2);  finish(2, -1);  hold_check(2, 1);

    // Load during build ignored; back-to-back load in the done cycle
    start(5);
    finish(5, 3);
    start(1);
    finish(1, -1);
    hold_check(1, 1);

    // Reset mid-build aborts immediately
    start(6);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sat", 32'(sat), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    start(6);
    finish(6, -1);

    // Popcount round trip across every legal count
    for (int k = 0; k <= int'(W); k++) begin
      tick();
      start(k);
      finish(k, -1);
    end

    // Randomized counts and idle gaps
    for (int k = 0; k < 30; k++) begin
      c = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
      end
      start(c);
      finish(c, int'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
